// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx / uart_rx pair.
// UART_TX_TWO_STOP_EN selects two stop bits instead of one.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif

    // Bit periods per frame: start + data + optional parity + stop bit(s).
    function automatic int frame_bits(input int data_bits, input int enable_parity);
        return 1 + data_bits + enable_parity + STOP_BITS;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// One-cycle tick every BAUD_DIV clk cycles, counted from the last clear.
// Shared by the UART transmitter and receiver.
module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // Wraps at BAUD_DIV-1 so consecutive bit periods never drift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, data LSB first, optional even parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV      = 434,
    parameter int DATA_BITS     = 8,
    parameter int ENABLE_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS) + 1;
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    state_t                 state, state_nx;
    logic [DATA_BITS-1:0]   shift_q, shift_nx;
    logic                   par_q, par_nx;
    logic [BW-1:0]          bit_q, bit_nx;
    logic                   tx_q, tx_nx;
    logic                   tick;
    logic                   accept;

    // Handshake: valid/ready both high on a rising edge transfers data_in;
    // the producer must hold data_in and valid until ready is seen.
    assign ready  = (state == IDLE);
    assign busy   = !ready;
    assign accept = valid && ready;
    assign tx     = tx_q;

    // Counter held at zero while idle, so START begins a fresh bit period.
    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nx;
            shift_q <= shift_nx;
            par_q   <= par_nx;
            bit_q   <= bit_nx;
            tx_q    <= tx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        shift_nx = shift_q;
        par_nx   = par_q;
        bit_nx   = bit_q;
        tx_nx    = 1'b1;

        case (state)
            IDLE: begin
                if (accept) begin
                    shift_nx = data_in;
                    par_nx   = ^data_in;
                    bit_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_nx   = '0;
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_nx = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_nx   = '0;
                        state_nx = (ENABLE_PARITY != 0) ? PARITY : STOP;
                    end else begin
                        bit_nx = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    bit_nx   = '0;
                    state_nx = STOP;
                end
            end
            STOP: begin
                // bit_q counts stop bits here.
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        bit_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        bit_nx = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                bit_nx   = '0;
                state_nx = IDLE;
            end
        endcase

        // Line level is decided from the next state so tx is registered with it.
        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            PARITY:  tx_nx = par_nx;
            default: tx_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one no-parity and one parity instance,
// checked against a bit-list frame model.
module tb_uart_tx;

    localparam int BD = 4;
    localparam int DB = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int SB = 2;
`else
    localparam int SB = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       valid_n, valid_p;
    logic [7:0] data_n, data_p;
    logic       tx_n, ready_n, busy_n;
    logic       tx_p, ready_p, busy_p;

    int checks = 0;
    int passes = 0;

    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(DB), .ENABLE_PARITY(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .data_in(data_n), .valid(valid_n),
        .ready(ready_n), .tx(tx_n), .busy(busy_n)
    );

    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(DB), .ENABLE_PARITY(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .data_in(data_p), .valid(valid_p),
        .ready(ready_p), .tx(tx_p), .busy(busy_p)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic void exp_frame(input bit par, input logic [7:0] d,
                                      output logic [63:0] bits, output int len);
        int q[$];
        q.push_back(0);
        for (int i = 0; i < DB; i++) q.push_back(int'(d[i]));
        if (par) q.push_back(int'(^d));
        for (int i = 0; i < SB; i++) q.push_back(1);
        len  = q.size() * BD;
        bits = '1;
        for (int b = 0; b < q.size(); b++)
            for (int k = 0; k < BD; k++)
                bits[b*BD+k] = q[b][0];
    endfunction

    // ---------------- driver / monitor tasks ----------------
    function automatic logic cur_tx(input bit par);
        return par ? tx_p : tx_n;
    endfunction
    function automatic logic cur_ready(input bit par);
        return par ? ready_p : ready_n;
    endfunction
    function automatic logic cur_busy(input bit par);
        return par ? busy_p : busy_n;
    endfunction

    task automatic set_in(input bit par, input logic v, input logic [7:0] d);
        if (par) begin
            valid_p = v;
            data_p  = d;
        end else begin
            valid_n = v;
            data_n  = d;
        end
    endtask

    // Offers d, waits (bounded) for the handshake edge; data_in is scrambled afterwards.
    task automatic accept(input bit par, input logic [7:0] d, input bit hold);
        bit ok;
        ok = 1'b0;
        set_in(par, 1'b1, d);
        for (int i = 0; i < 400; i++) begin
            if (cur_ready(par) === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (ok) passes++;
        else $display("FAIL accept_timeout: ready never seen for word %h", d);
        set_in(par, hold, ~d);
    endtask

    task automatic capture(input bit par, input int len, input int raise_at,
                           input logic [7:0] d2, output logic [63:0] obs,
                           output int busy_hi, output int ready_hi);
        obs = '1;
        busy_hi = 0;
        ready_hi = 0;
        for (int c = 0; c < len; c++) begin
            if (c == raise_at) set_in(par, 1'b1, d2);
            obs[c] = cur_tx(par);
            busy_hi += int'(cur_busy(par) === 1'b1);
            ready_hi += int'(cur_ready(par) === 1'b1);
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad_tx, bad_ready, bad_busy;
        bad_tx = 0; bad_ready = 0; bad_busy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 50; c++) begin
            bad_tx    += int'(tx_n !== 1'b1) + int'(tx_p !== 1'b1);
            bad_ready += int'(ready_n !== 1'b1) + int'(ready_p !== 1'b1);
            bad_busy  += int'(busy_n !== 1'b0) + int'(busy_p !== 1'b0);
            @(posedge clk); #1;
        end
        checks++; if (bad_tx === 0) passes++; else $display("FAIL idle_tx: %0d bad cycles, required 0", bad_tx);
        checks++; if (bad_ready === 0) passes++; else $display("FAIL idle_ready: %0d bad cycles, required 0", bad_ready);
        checks++; if (bad_busy === 0) passes++; else $display("FAIL idle_busy: %0d bad cycles, required 0", bad_busy);

        // Start a frame of zeros on both, then reset in the middle of it.
        set_in(0, 1'b1, 8'h00);
        set_in(1, 1'b1, 8'h00);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({tx_n, tx_p} === 2'b00) passes++;
        else $display("FAIL midframe_low: tx=%b%b required 00", tx_n, tx_p);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_n, tx_p, ready_n, ready_p, busy_n, busy_p} === 6'b111100) passes++;
        else $display("FAIL async_reset: tx/ready/busy=%b%b%b%b%b%b required 111100",
                      tx_n, tx_p, ready_n, ready_p, busy_n, busy_p);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        bad_tx = 0;
        for (int c = 0; c < 100; c++) begin
            bad_tx += int'(tx_n !== 1'b1) + int'(tx_p !== 1'b1)
                    + int'(busy_n !== 1'b0) + int'(busy_p !== 1'b0);
            @(posedge clk); #1;
        end
        checks++;
        if (bad_tx === 0) passes++;
        else $display("FAIL no_resume: %0d bad samples after reset, required 0", bad_tx);
    endtask

    task automatic test_basic_frame();
        logic [63:0] obs, exp;
        int len, busy_hi, ready_hi;
        exp_frame(0, 8'hA5, exp, len);
        accept(0, 8'hA5, 0);
        capture(0, len, -1, 8'h00, obs, busy_hi, ready_hi);
        checks++; if (obs === exp) passes++; else $display("FAIL frame_a5: got %h required %h", obs, exp);
        checks++; if (busy_hi === (1 + DB + SB) * BD) passes++; else $display("FAIL busy_len_a5: got %0d required %0d", busy_hi, (1 + DB + SB) * BD);
        checks++; if (ready_hi === 0) passes++; else $display("FAIL ready_low_a5: ready high %0d cycles, required 0", ready_hi);
        checks++; if ({ready_n, tx_n, busy_n} === 3'b110) passes++; else $display("FAIL post_frame: ready/tx/busy=%b%b%b required 110", ready_n, tx_n, busy_n);
    endtask

    task automatic test_parity();
        logic [63:0] obs, exp;
        int len, busy_hi, ready_hi;
        logic [7:0] words [2];
        logic       pbit  [2];
        words[0] = 8'h07; pbit[0] = 1'b1;
        words[1] = 8'h03; pbit[1] = 1'b0;
        for (int w = 0; w < 2; w++) begin
            exp_frame(1, words[w], exp, len);
            accept(1, words[w], 0);
            capture(1, len, -1, 8'h00, obs, busy_hi, ready_hi);
            checks++; if (obs === exp) passes++; else $display("FAIL frame_par_%h: got %h required %h", words[w], obs, exp);
            checks++; if (obs[(1 + DB) * BD + 1] === pbit[w]) passes++; else $display("FAIL parity_bit_%h: got %b required %b", words[w], obs[(1 + DB) * BD + 1], pbit[w]);
            checks++; if (busy_hi === (2 + DB + SB) * BD) passes++; else $display("FAIL busy_len_par_%h: got %0d required %0d", words[w], busy_hi, (2 + DB + SB) * BD);
        end
    endtask

    task automatic test_random();
        logic [63:0] obs, exp;
        int len, busy_hi, ready_hi;
        bit par;
        logic [7:0] d;
        for (int i = 0; i < 8; i++) begin
            par = bit'($urandom_range(1, 0));
            d   = 8'($urandom);
            exp_frame(par, d, exp, len);
            accept(par, d, 0);
            capture(par, len, -1, 8'h00, obs, busy_hi, ready_hi);
            checks++; if (obs === exp) passes++; else $display("FAIL rand_frame p%0d d%h: got %h required %h", par, d, obs, exp);
            checks++; if (busy_hi === len) passes++; else $display("FAIL rand_busy p%0d d%h: got %0d required %0d", par, d, busy_hi, len);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #0;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] obs, exp;
        int len, busy_hi, ready_hi;
        for (int p = 0; p < 2; p++) begin
            exp_frame(bit'(p), 8'h55, exp, len);
            accept(bit'(p), 8'h55, 1);
            set_in(bit'(p), 1'b1, 8'hFF);
            capture(bit'(p), len, -1, 8'h00, obs, busy_hi, ready_hi);
            checks++; if (obs === exp) passes++; else $display("FAIL b2b_first p%0d: got %h required %h", p, obs, exp);
            checks++; if ({cur_ready(bit'(p)), cur_tx(bit'(p))} === 2'b11) passes++;
            else $display("FAIL b2b_gap p%0d: ready/tx=%b%b required 11", p, cur_ready(bit'(p)), cur_tx(bit'(p)));
            @(posedge clk); #1;
            set_in(bit'(p), 1'b0, 8'h00);
            exp_frame(bit'(p), 8'hFF, exp, len);
            capture(bit'(p), len, -1, 8'h00, obs, busy_hi, ready_hi);
            checks++; if (obs === exp) passes++; else $display("FAIL b2b_second p%0d: got %h required %h", p, obs, exp);
        end
    endtask

    task automatic test_valid_while_busy();
        logic [63:0] obs, exp;
        int len, busy_hi, ready_hi, extra;
        exp_frame(1, 8'h81, exp, len);
        accept(1, 8'h81, 0);
        capture(1, len, 6, 8'h12, obs, busy_hi, ready_hi);
        checks++; if (obs === exp) passes++; else $display("FAIL busy_first: got %h required %h", obs, exp);
        checks++; if (ready_hi === 0) passes++; else $display("FAIL busy_ready: ready high %0d cycles, required 0", ready_hi);
        checks++; if (ready_p === 1'b1) passes++; else $display("FAIL busy_idle_ready: got %b required 1", ready_p);
        @(posedge clk); #1;
        set_in(1, 1'b0, 8'hED);
        exp_frame(1, 8'h12, exp, len);
        capture(1, len, -1, 8'h00, obs, busy_hi, ready_hi);
        checks++; if (obs === exp) passes++; else $display("FAIL busy_held_word: got %h required %h", obs, exp);
        extra = 0;
        for (int c = 0; c < 3 * len; c++) begin
            extra += int'(tx_p !== 1'b1) + int'(busy_p !== 1'b0);
            @(posedge clk); #1;
        end
        checks++; if (extra === 0) passes++; else $display("FAIL sent_once: %0d bad samples, required 0", extra);
    endtask

    initial begin
        rst_n = 1'b0;
        valid_n = 1'b0; valid_p = 1'b0;
        data_n = 8'h00; data_p = 8'h00;
        test_reset();
        test_basic_frame();
        test_parity();
        test_random();
        test_back_to_back();
        test_valid_while_busy();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
